// File: rtl/ntt_dout_collector_pkg.sv
// Shared definitions for the NTT output collector: FSM encoding and depth limits.
package ntt_dout_collector_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    localparam int RING_DEPTH_MIN    = 3;
    localparam int MAX_DEPTH_DEFAULT = 10;

endpackage

// File: rtl/ntt_collect_ram.sv
// Simple dual-port coefficient buffer: synchronous write, registered read that
// only updates on rd_en so the read word holds while the consumer stalls.
module ntt_collect_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Contents are deliberately not reset; a drain only ever follows a full capture.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ntt_dout_collector.sv
// Collects interleaved NTT output beats and replays them in natural order.
// Optional build macro NTT_COLLECT_REDUCE_EN: conditional subtract of q before write.
module ntt_dout_collector
    import ntt_dout_collector_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_DEPTH = MAX_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        ring_depth,
    input  logic [DATA_W-1:0] q,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = MAX_DEPTH + 1;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    logic              depth_ok;
    logic              accept_start;
    logic              handshake;
    logic              wr_en;
    logic              rd_en;
    logic [CW-1:0]     n_last;
    logic [CW-1:0]     wr_addr_full;
    logic [DATA_W-1:0] wr_data;

    assign depth_ok     = (int'(ring_depth) >= RING_DEPTH_MIN) && (int'(ring_depth) <= MAX_DEPTH);
    assign accept_start = (state_q == ST_IDLE) && start && depth_ok;
    assign handshake    = out_valid_q && out_ready;
    assign n_last       = n_q - CW'(1);

    // Even beats fill the lower half, odd beats the upper half.
    always_comb begin
        wr_addr_full = wr_cnt_q >> 1;
        if (wr_cnt_q[0]) begin
            wr_addr_full = (wr_cnt_q >> 1) + (n_q >> 1);
        end
    end

`ifdef NTT_COLLECT_REDUCE_EN
    logic [DATA_W-1:0] q_q, q_d;

    assign q_d     = accept_start ? q : q_q;
    assign wr_data = (in_data >= q_q) ? (in_data - q_q) : in_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end
`else
    logic unused_q;

    assign unused_q = ^q;
    assign wr_data  = in_data;
`endif

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        err_d       = err_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (depth_ok) begin
                        n_d      = CW'(1) << ring_depth;
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                        err_d    = 1'b0;
                        state_d  = ST_CAPTURE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_CAPTURE: begin
                if (in_valid) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = wr_cnt_q + CW'(1);
                    if (wr_cnt_q == n_last) begin
                        rd_cnt_d = '0;
                        state_d  = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (in_valid) begin
                    err_d = 1'b1;
                end
                if (handshake) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        out_last_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                // Fetch the next word only once the output slot is free or being freed.
                if ((rd_cnt_q != n_q) && (!out_valid_q || handshake)) begin
                    rd_en       = 1'b1;
                    rd_cnt_d    = rd_cnt_q + CW'(1);
                    out_valid_d = 1'b1;
                    out_last_d  = (rd_cnt_q == n_last);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    ntt_collect_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (MAX_DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (MAX_DEPTH'(wr_addr_full)),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (MAX_DEPTH'(rd_cnt_q)),
        .rd_data (out_data)
    );

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ntt_dout_collector.sv
// Scoreboard bench for ntt_dout_collector: interleaved frames in, natural order out.
module tb_ntt_dout_collector;

  localparam int DATA_W = 32;
  localparam int W      = DATA_W + 1;
  localparam int QMOD   = 8004097;
  localparam int TMO    = 20000;

  logic              clk;
  logic              reset;
  logic              start;
  logic [3:0]        ring_depth;
  logic [DATA_W-1:0] q;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err;

  // Handshake: a word transfers on a rising edge where out_valid and out_ready are both 1.
  ntt_dout_collector #(.DATA_W(DATA_W), .MAX_DEPTH(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ring_depth (ring_depth),
    .q          (q),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] beats[1024];
  int n_cmp = 0;
  int n_err = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  int hold_cnt = 0;
  bit rand_ready = 0;
  bit stall_en = 0;
  int stall_left = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_val(input logic [DATA_W-1:0] v, input logic [DATA_W-1:0] qv);
`ifdef NTT_COLLECT_REDUCE_EN
    return (v >= qv) ? v - qv : v;
`else
    return (qv == qv) ? v : v;
`endif
  endfunction

  // driver tasks
  task automatic start_frame(input int depth);
    out_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    ring_depth = 4'(depth);
    q = QMOD;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: m+1, mode 1: random in [0,2q), mode 2: reduce corner values then m+1
  task automatic send_frame(input int depth, input int mode, input int nbeats, input bit gaps);
    int n;
    logic [DATA_W-1:0] v;
    int idx;
    n = 1 << depth;
    for (int m = 0; m < nbeats; m++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      case (mode)
        1: v = DATA_W'($urandom_range(0, 2 * QMOD - 1));
        2: v = (m == 0) ? 32'd8004100 : (m == 1) ? 32'd8004096 : DATA_W'(m + 1);
        default: v = DATA_W'(m + 1);
      endcase
      beats[m] = v;
      in_valid = 1'b1;
      in_data = v;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (nbeats == n) begin
      for (int k = 0; k < n; k++) begin
        idx = (k < n / 2) ? 2 * k : 2 * (k - n / 2) + 1;
        exp_q.push_back({(k == n - 1), model_val(beats[idx], QMOD)});
      end
    end
  endtask

  task automatic wait_frame(input int n);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || done_cnt == 0) && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    check("frame_timeout", (cyc < TMO), 1);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("out_count", out_cnt, n);
    check("busy_after", busy, 0);
    check("valid_after", out_valid, 0);
    @(posedge clk); #1;
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_en && out_cnt == 10 && out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // scoreboard monitor, sampled on the falling edge
  initial begin
    logic [W-1:0]      e;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;
    bit                prev_stall;
    prev_stall = 0;
    prev_data = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          hold_cnt++;
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, prev_data);
          check("hold_last", out_last, prev_last);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_nonempty", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e[DATA_W-1:0]);
            check("out_last", out_last, e[DATA_W]);
          end
          out_cnt++;
        end
        if (done) done_cnt++;
        prev_stall = out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
      end
    end
  end

  initial begin
    int lat;
    reset = 1'b1;
    start = 1'b0;
    ring_depth = 4'd0;
    q = '0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // stray beats in IDLE are ignored
    in_valid = 1'b1; in_data = 32'd77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("idle_beat_busy", busy, 0);

    // natural-order check with m+1 data, N=256
    start_frame(8);
    check("busy_capture", busy, 1);
    send_frame(8, 0, 256, 0);
    lat = 0;
    while (!out_valid && lat < 4) begin
      @(negedge clk);
      if (!out_valid) lat++;
    end
    check("drain_latency_ok", (lat <= 2), 1);
    @(posedge clk); #1;
    wait_frame(256);
    check("err_clean", err, 0);

    // reduce corner values
    start_frame(3);
    send_frame(3, 2, 8, 0);
    wait_frame(8);

    // stall of 5 cycles at index 10, N=32
    stall_en = 1;
    stall_left = 5;
    hold_cnt = 0;
    start_frame(5);
    send_frame(5, 1, 32, 1);
    wait_frame(32);
    check("stall_holds", (hold_cnt >= 5), 1);
    stall_en = 0;

    // random backpressure, random data, N=16 and N=1024
    rand_ready = 1;
    start_frame(4);
    send_frame(4, 1, 16, 1);
    wait_frame(16);
    start_frame(10);
    send_frame(10, 1, 1024, 0);
    wait_frame(1024);
    rand_ready = 0;

    // reset mid-capture
    start_frame(8);
    send_frame(8, 1, 50, 0);
    reset = 1'b1;
    #2;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    start_frame(3);
    send_frame(3, 0, 8, 0);
    wait_frame(8);

    // illegal depths
    start_frame(2);
    check("bad_depth2_err", err, 1);
    check("bad_depth2_busy", busy, 0);
    start_frame(3);
    check("good_start_clears_err", err, 0);
    send_frame(3, 1, 8, 0);
    wait_frame(8);
    start_frame(11);
    check("bad_depth11_err", err, 1);
    check("bad_depth11_busy", busy, 0);

    // beat and start during DRAIN
    start_frame(3);
    send_frame(3, 0, 8, 0);
    in_valid = 1'b1;
    in_data = 32'hdead;
    start = 1'b1;
    ring_depth = 4'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    start = 1'b0;
    check("drain_beat_err", err, 1);
    check("drain_busy", busy, 1);
    wait_frame(8);
    check("err_sticky", err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
